led_scan_ctrl: RTL and testbench
================================

Name: led_scan_ctrl

Overview:
- Autonomous LED-matrix scanner: CPU writes a 20-line x 10-bit frame buffer through local I/O ports; the block reads it back line by line and drives the board's line-select and column outputs.
- Replaces CPU-timed per-line writes with hardware scan timing and inter-line blanking.
- Sits on the CPU I/O bus beside the input-switch port; its outputs go straight to the external board pins.

Parameters:
- LINES, 20, number of matrix lines (line-select width).
- COLS, 10, column data width.
- BLANK_CYC, 4, all-lines-off cycles inserted before each line.
- PERIOD_RST, 16'd1000, reset value of the line-on period register, in clocks.

Ports:
- iClk  in  1  system clock.
- iRst  in  1  asynchronous, active-high reset.
- iAddr  in  4  local port address.
- iData  in  16  CPU write data.
- iWEnb  in  1  port write enable, one cycle per write.
- oData  out  16  status readback (combinational from registers).
- oLED_Data  out  COLS  column data, active-high.
- oLED_LineSel  out  LINES  line select, active-low, at most one bit low.
- oFrameTick  out  1  one-cycle pulse at end of each frame.

Behaviour:
- Ports:
  - 0 = WrPtr: bits [4:0], values >= LINES are ignored.
  - 1 = FBData: writes fb[WrPtr] <= iData[COLS-1:0]; WrPtr auto-increments and wraps LINES-1 -> 0.
  - 2 = Period: 16-bit line-on time; a write of 0 is stored as 1.
  - 3 = Ctrl: bit0 Enable.
- oData:
  - Addr 0: {11'b0, WrPtr}.
  - Addr 3: {FrameCnt[7:0], 2'b0, Line[4:0], Enable}.
  - Others: 0.
- Reset (async): oLED_LineSel = all 1s; oLED_Data = 0; oFrameTick = 0; Line = 0; WrPtr = 0; Period = PERIOD_RST; Enable = 0; FrameCnt = 0. Frame buffer is cleared to 0.
- FSM:
  - IDLE: outputs at their reset values. Moves to BLANK when Enable = 1. Line = 0.
  - BLANK: LineSel = all 1s; Data = 0; counts BLANK_CYC cycles, then DRIVE.
  - DRIVE: LineSel bit [Line] = 0; Data = fb[Line], registered, so it appears 1 cycle after entry.
    - Lasts Period cycles.
    - At expiry: Line increments and the FSM returns to BLANK.
    - At Line = LINES-1 expiry: Line wraps to 0, oFrameTick pulses for 1 cycle, FrameCnt increments mod 256.
- Outputs are registered: LineSel and Data change on the same edge, and there is never an overlap of two active lines.
- Enable cleared in any state: next cycle -> IDLE; outputs blanked; Line reset to 0; no frame tick.
- Period write during DRIVE:
  - The counter restarts from 0 with the new value.
  - A new value at or below the elapsed count ends the line next cycle.
- FB write to the currently driven line takes effect at the next DRIVE entry of that line, not mid-line.
- Port writes with iWEnb low are ignored. Addresses 4..15 are ignored.
- The period counter is 16-bit and saturates; it never wraps.

Optional Feature:
- LED_SCAN_DIMMER_EN:
  - Adds port 4 = Duty[7:0].
  - During DRIVE, the line is active only while the cycle count within the line, scaled by (count*256/Period), is below Duty; otherwise LineSel = all 1s and Data is held.
  - Duty = 255 means always on. Duty = 0 means dark.
  - Duty resets to 255.
- Without the macro:
  - Line is full-on for the whole DRIVE.
  - Port 4 is ignored.

Decomposition:
- Shared package (EXTBoard defs):
  - Port constants PORT_ScanPtr/PORT_ScanData/PORT_ScanPeriod/PORT_ScanCtrl/PORT_ScanDuty.
  - tPORT.
  - Scan state encoding IDLE/BLANK/DRIVE.
- Sub-module led_fb_ram: LINES x COLS register file, one write port, one registered read port.

Test Plan:
- Reset then idle: oLED_LineSel = 20'hFFFFF and oLED_Data = 0 indefinitely.
- Ptr := 0, write 20 FBData words 0x001..0x014, Period := 8, Ctrl := 1 -> per line: 4 blank cycles, then 8 cycles with LineSel bit n low and Data = n+1; oFrameTick exactly once per 240 cycles; WrPtr reads back 0 after the wrap.
- Ctrl := 0 while line 7 is driving -> next cycle all lines high; status Line = 0; no tick.
- Period := 0 -> stored as 1: each line drives 1 cycle, frame = 100 cycles.
- Write fb[3] := 0x3FF while line 3 is driving -> old data for the rest of the line, 0x3FF on the next frame.
- (LED_SCAN_DIMMER_EN) Duty := 128, Period := 256 -> line low for 128 cycles, high for 128 within each DRIVE.

Source files
------------

// File: rtl/led_scan_ctrl_pkg.sv
// rtl/led_scan_ctrl_pkg.sv - EXTBoard scan definitions: matrix geometry, local port map, scan states.
package led_scan_ctrl_pkg;
    localparam int LINES = 20;
    localparam int COLS = 10;
    localparam int BLANK_CYC = 4;
    localparam logic [15:0] PERIOD_RST = 16'd1000;
    localparam int LINE_W = 5;

    typedef enum logic [3:0] {
        PORT_ScanPtr    = 4'd0,
        PORT_ScanData   = 4'd1,
        PORT_ScanPeriod = 4'd2,
        PORT_ScanCtrl   = 4'd3,
        PORT_ScanDuty   = 4'd4
    } tPORT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } tScanState;

    function automatic logic [LINE_W-1:0] nextLine(input logic [LINE_W-1:0] l);
        return (l == LINE_W'(LINES - 1)) ? '0 : l + 1'b1;
    endfunction
endpackage

// File: rtl/led_fb_ram.sv
// rtl/led_fb_ram.sv - LINES x COLS frame buffer, one write port, one registered read port.
module led_fb_ram
    import led_scan_ctrl_pkg::*;
(
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iWEnb,
    input  logic [LINE_W-1:0] iWAddr,
    input  logic [COLS-1:0]   iWData,
    input  logic [LINE_W-1:0] iRAddr,
    output logic [COLS-1:0]   oRData
);
    logic [COLS-1:0] mem [LINES];

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < LINES; i++) begin
                mem[i] <= '0;
            end
            oRData <= '0;
        end else begin
            if (iWEnb) begin
                mem[iWAddr] <= iWData;
            end
            oRData <= mem[iRAddr];
        end
    end
endmodule

// File: rtl/led_scan_ctrl.sv
// rtl/led_scan_ctrl.sv - autonomous LED-matrix scanner with blanking; LED_SCAN_DIMMER_EN adds a per-line duty dimmer.
module led_scan_ctrl
    import led_scan_ctrl_pkg::*;
(
    input  logic             iClk,
    input  logic             iRst,
    input  logic [3:0]       iAddr,
    input  logic [15:0]      iData,
    input  logic             iWEnb,
    output logic [15:0]      oData,
    output logic [COLS-1:0]  oLED_Data,
    output logic [LINES-1:0] oLED_LineSel,
    output logic             oFrameTick
);
    tScanState         state;
    tPORT              port;
    logic [LINE_W-1:0] line;
    logic [LINE_W-1:0] wrPtr;
    logic [15:0]       period;
    logic [15:0]       cnt;
    logic [15:0]       newPeriod;
    logic [7:0]        frameCnt;
    logic [COLS-1:0]   rdData;
    logic              enable;
    logic              inDrive;
    logic              ptrWr, dataWr, periodWr, ctrlWr;
    logic              run, lastCyc, lineOn;

    assign port      = tPORT'(iAddr);
    assign ptrWr     = iWEnb && (port == PORT_ScanPtr);
    assign dataWr    = iWEnb && (port == PORT_ScanData);
    assign periodWr  = iWEnb && (port == PORT_ScanPeriod);
    assign ctrlWr    = iWEnb && (port == PORT_ScanCtrl);
    assign newPeriod = (iData == 16'd0) ? 16'd1 : iData;
    // A Ctrl write acts on the same edge so disabling blanks the pins one cycle later.
    assign run       = ctrlWr ? iData[0] : enable;
    assign lastCyc   = cnt >= (period - 16'd1);

`ifdef LED_SCAN_DIMMER_EN
    logic [7:0] duty;
    logic       dutyWr;

    assign dutyWr = iWEnb && (port == PORT_ScanDuty);
    // count*256/Period < Duty, rearranged to avoid a divider.
    assign lineOn = (duty == 8'hFF) || ({cnt, 8'h00} < (24'(duty) * 24'(period)));

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            duty <= 8'hFF;
        end else if (dutyWr) begin
            duty <= iData[7:0];
        end
    end
`else
    assign lineOn = 1'b1;
`endif

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wrPtr  <= '0;
            period <= PERIOD_RST;
            enable <= 1'b0;
        end else begin
            if (ptrWr) begin
                if (iData[4:0] < LINE_W'(LINES)) begin
                    wrPtr <= iData[4:0];
                end
            end else if (dataWr) begin
                wrPtr <= nextLine(wrPtr);
            end
            if (periodWr) begin
                period <= newPeriod;
            end
            if (ctrlWr) begin
                enable <= iData[0];
            end
        end
    end

    led_fb_ram uFbRam (
        .iClk   (iClk),
        .iRst   (iRst),
        .iWEnb  (dataWr),
        .iWAddr (wrPtr),
        .iWData (iData[COLS-1:0]),
        .iRAddr (line),
        .oRData (rdData)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state        <= IDLE;
            line         <= '0;
            cnt          <= '0;
            frameCnt     <= '0;
            inDrive      <= 1'b0;
            oLED_LineSel <= '1;
            oLED_Data    <= '0;
            oFrameTick   <= 1'b0;
        end else begin
            oFrameTick <= 1'b0;
            inDrive    <= (state == DRIVE);
            if (!run) begin
                state        <= IDLE;
                line         <= '0;
                cnt          <= '0;
                inDrive      <= 1'b0;
                oLED_LineSel <= '1;
                oLED_Data    <= '0;
            end else begin
                oLED_LineSel <= (state == DRIVE && lineOn) ? ~(LINES'(1) << line) : '1;
                // Column data is latched once per line so buffer writes never tear a lit line.
                oLED_Data    <= (state != DRIVE) ? '0 : (inDrive ? oLED_Data : rdData);
                unique case (state)
                    IDLE: begin
                        state <= BLANK;
                        cnt   <= '0;
                    end
                    BLANK: begin
                        if (cnt == 16'(BLANK_CYC - 1)) begin
                            state <= DRIVE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    DRIVE: begin
                        if (periodWr) begin
                            cnt <= (newPeriod <= cnt) ? newPeriod - 16'd1 : 16'd0;
                        end else if (lastCyc) begin
                            state <= BLANK;
                            cnt   <= '0;
                            line  <= nextLine(line);
                            if (line == LINE_W'(LINES - 1)) begin
                                oFrameTick <= 1'b1;
                                frameCnt   <= frameCnt + 8'd1;
                            end
                        end else if (cnt != 16'hFFFF) begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        oData = '0;
        if (port == PORT_ScanPtr) begin
            oData = {11'b0, wrPtr};
        end else if (port == PORT_ScanCtrl) begin
            oData = {frameCnt, 2'b0, line, enable};
        end
    end
endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb/tb_led_scan_ctrl.sv - self-checking bench for led_scan_ctrl; also covers LED_SCAN_DIMMER_EN when defined.
`timescale 1ns/1ps
module tb_led_scan_ctrl;
    import led_scan_ctrl_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       addr = 4'd0;
    logic [15:0]      wdata = 16'd0;
    logic             we = 1'b0;
    logic [15:0]      rdata;
    logic [COLS-1:0]  ledData;
    logic [LINES-1:0] lineSel;
    logic             tick;

    always #5 clk = ~clk;

    led_scan_ctrl dut (
        .iClk         (clk),
        .iRst         (rst),
        .iAddr        (addr),
        .iData        (wdata),
        .iWEnb        (we),
        .oData        (rdata),
        .oLED_Data    (ledData),
        .oLED_LineSel (lineSel),
        .oFrameTick   (tick)
    );

    typedef struct {
        logic [LINES-1:0] sel;
        logic [COLS-1:0]  data;
        int               len;
    } tSeg;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        logic        we;
        logic [3:0]  raddr;
        logic [15:0] exp;
    } tVec;

    int  checks = 0;
    int  failures = 0;
    tSeg expQ[$];
    bit  monEn = 1'b0;
    int  expGap = 4;
    int  cycle = 0;
    int  tickCnt = 0;
    int  tickAt[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic portWrite(input logic [3:0] a, input logic [15:0] d, input logic en);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = en;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic portRead(input logic [3:0] a, output logic [15:0] d);
        @(negedge clk);
        addr = a;
        #1 d = rdata;
    endtask

    task automatic pushLines(input int count, input int len, input logic [COLS-1:0] d3);
        for (int i = 0; i < count; i++) begin
            tSeg s;
            int  ln;
            ln     = i % LINES;
            s.sel  = ~(LINES'(1) << ln);
            s.data = (ln == 3) ? d3 : COLS'(ln + 1);
            s.len  = len;
            expQ.push_back(s);
        end
    endtask

    bit               segActive = 1'b0;
    bit               gapValid = 1'b0;
    bit               segStable;
    bit               curValid = 1'b0;
    int               segLen;
    int               gapLen;
    logic [LINES-1:0] segSel;
    logic [COLS-1:0]  segData;
    tSeg              cur;

    task automatic waitDone(input string name, input int budget);
        int n;
        n = 0;
        while ((expQ.size() != 0 || segActive) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_done"}, 32'(expQ.size() == 0 && !segActive), 32'd1);
    endtask

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    // Line segment monitor: each lit stretch is matched against the next expected line.
    initial forever begin
        @(negedge clk);
        if (tick === 1'b1) begin
            if (tickCnt < 8) tickAt[tickCnt] = cycle;
            tickCnt++;
        end
        if (!monEn) begin
            segActive = 1'b0;
            gapValid  = 1'b0;
        end else if (lineSel !== '1) begin
            if (!segActive) begin
                segActive = 1'b1;
                segLen    = 1;
                segSel    = lineSel;
                segData   = ledData;
                segStable = 1'b1;
                if (gapValid) check("blank_gap", 32'(gapLen), 32'(expGap));
                curValid = (expQ.size() != 0);
                check("seg_expected", 32'(curValid), 32'd1);
                if (curValid) begin
                    cur = expQ.pop_front();
                    check("seg_linesel", 32'(lineSel), 32'(cur.sel));
                end
            end else begin
                segLen++;
                if (lineSel !== segSel || ledData !== segData) segStable = 1'b0;
            end
        end else if (segActive) begin
            segActive = 1'b0;
            gapValid  = 1'b1;
            gapLen    = 1;
            check("seg_stable", 32'(segStable), 32'd1);
            if (curValid) begin
                check("seg_data", 32'(segData), 32'(cur.data));
                check("seg_len", 32'(segLen), 32'(cur.len));
            end
        end else begin
            gapLen++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

    initial begin
        tVec         vec[10];
        logic [15:0] r;
        int          n;
        int          bad;

        vec[0] = '{4'd0, 16'd5,      1'b1, 4'd0, 16'd5};
        vec[1] = '{4'd0, 16'd25,     1'b1, 4'd0, 16'd5};
        vec[2] = '{4'd0, 16'd19,     1'b1, 4'd0, 16'd19};
        vec[3] = '{4'd0, 16'd3,      1'b0, 4'd0, 16'd19};
        vec[4] = '{4'd9, 16'd7,      1'b1, 4'd0, 16'd19};
        vec[5] = '{4'd1, 16'h02AA,   1'b1, 4'd0, 16'd0};
        vec[6] = '{4'd1, 16'h0155,   1'b1, 4'd0, 16'd1};
        vec[7] = '{4'd2, 16'h1234,   1'b1, 4'd2, 16'd0};
        vec[8] = '{4'd3, 16'd0,      1'b1, 4'd3, 16'd0};
        vec[9] = '{4'd4, 16'h0055,   1'b1, 4'd4, 16'd0};

        repeat (3) @(negedge clk);
        check("rst_linesel", 32'(lineSel), 32'h000F_FFFF);
        check("rst_data", 32'(ledData), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        rst = 1'b0;
        addr = 4'd0;
        #1 check("rst_wrptr", 32'(rdata), 32'd0);
        addr = 4'd3;
        #1 check("rst_status", 32'(rdata), 32'd0);
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (lineSel !== '1 || ledData !== '0 || tick !== 1'b0) bad++;
        end
        check("idle_dark", 32'(bad), 32'd0);

        for (int i = 0; i < 10; i++) begin
            portWrite(vec[i].addr, vec[i].data, vec[i].we);
            portRead(vec[i].raddr, r);
            check($sformatf("port_vec%0d", i), 32'(r), 32'(vec[i].exp));
        end

        // Full frame scan at Period 8, then disable while line 7 is lit.
        portWrite(4'd0, 16'd0, 1'b1);
        for (int i = 0; i < LINES; i++) portWrite(4'd1, 16'(i + 1), 1'b1);
        portRead(4'd0, r);
        check("wrptr_wrap", 32'(r), 32'd0);
        portWrite(4'd2, 16'd8, 1'b1);
        monEn  = 1'b1;
        expGap = 4;
        pushLines(48, 8, 10'd4);
        portWrite(4'd3, 16'd1, 1'b1);
        n = 0;
        while (expQ.size() != 0 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("frames_drained", 32'(expQ.size()), 32'd0);
        check("line7_lit", 32'(lineSel), 32'h000F_FF7F);
        monEn = 1'b0;
        portWrite(4'd3, 16'd0, 1'b1);
        check("disable_linesel", 32'(lineSel), 32'h000F_FFFF);
        check("disable_data", 32'(ledData), 32'd0);
        portRead(4'd3, r);
        check("disable_status", 32'(r), 32'h0000_0200);
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (lineSel !== '1 || tick !== 1'b0) bad++;
        end
        check("disabled_dark", 32'(bad), 32'd0);
        check("tick_count_p8", 32'(tickCnt), 32'd2);
        check("frame_period_240", 32'(tickAt[1] - tickAt[0]), 32'd240);

        // Period 0 is stored as 1.
        portWrite(4'd2, 16'd0, 1'b1);
        monEn = 1'b1;
        pushLines(40, 1, 10'd4);
        portWrite(4'd3, 16'd1, 1'b1);
        waitDone("period1", 2000);
        monEn = 1'b0;
        portWrite(4'd3, 16'd0, 1'b1);
        check("tick_count_p1", 32'(tickCnt), 32'd4);
        check("frame_period_100", 32'(tickAt[3] - tickAt[2]), 32'd100);

        // Buffer write to the lit line shows up only on the next frame.
        portWrite(4'd2, 16'd8, 1'b1);
        monEn = 1'b1;
        pushLines(20, 8, 10'd4);
        pushLines(20, 8, 10'h3FF);
        portWrite(4'd3, 16'd1, 1'b1);
        n = 0;
        while (lineSel !== 20'hFFFF7 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("line3_lit", 32'(lineSel), 32'h000F_FFF7);
        portWrite(4'd0, 16'd3, 1'b1);
        portWrite(4'd1, 16'h03FF, 1'b1);
        waitDone("fb_write", 2000);
        monEn = 1'b0;
        portWrite(4'd3, 16'd0, 1'b1);

`ifdef LED_SCAN_DIMMER_EN
        portWrite(4'd4, 16'd128, 1'b1);
        portWrite(4'd2, 16'd256, 1'b1);
        monEn  = 1'b1;
        expGap = 132;
        pushLines(3, 128, 10'h3FF);
        portWrite(4'd3, 16'd1, 1'b1);
        waitDone("dimmer", 2000);
        monEn = 1'b0;
        portWrite(4'd3, 16'd0, 1'b1);
`endif

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
